data_memory_unit: RTL and testbench

- Responder end of the core's data-memory bus: accepts the core's read/write/address/data_out and returns data_in.
- Holds a word-addressed RAM plus a small memory-mapped peripheral window:
  - free-running cycle counter
  - TX FIFO that drains to an external host over a valid/ready stream
  - status/control register
- Sits beside the core at top level, in place of a bare data RAM.

---
 rtl/data_memory_unit_if.sv | 25 ++
 rtl/data_memory_unit.sv | 112 +++++++++++
 tb/tb_data_memory_unit.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/data_memory_unit_if.sv
// rtl/data_memory_unit_if.sv - core data-memory bus plus TX stream and fault pulse.
interface data_memory_unit_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] data_in;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic              wp_fault;

  modport slave (
    input  read, write, address, data_out, tx_ready,
    output data_in, tx_valid, tx_data, wp_fault
  );

  modport master (
    output read, write, address, data_out, tx_ready,
    input  data_in, tx_valid, tx_data, wp_fault
  );
endinterface

// File: rtl/data_memory_unit.sv
// rtl/data_memory_unit.sv - data RAM with cycle counter, TX FIFO and status window.
// Optional write protection of low RAM words under macro DMEM_WP_EN.
module data_memory_unit #(
  parameter int ADDR_W        = 10,
  parameter int DATA_W        = 32,
  parameter int FIFO_DEPTH    = 8,
  parameter int PROTECT_LIMIT = 16
) (
  input  logic                clock,
  input  logic                reset,
  data_memory_unit_if.slave   bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] A_CYCLE  = ADDR_W'((1 << ADDR_W) - 4);
  localparam logic [ADDR_W-1:0] A_TX     = ADDR_W'((1 << ADDR_W) - 3);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'((1 << ADDR_W) - 2);
  localparam logic [PTR_W:0]    FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] ram      [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] fifo_mem [0:FIFO_DEPTH-1];

  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [PTR_W:0]    count;
  logic [DATA_W-1:0] cycle;
  logic              overflow, wp_sticky, wp_fault_q;

  logic              is_ram, empty, full, pop, push_req, push, ovf_set;
  logic              st_wr, wp_block, ram_we;
  logic [DATA_W-1:0] head, status, rd_word;

  assign is_ram   = bus.address < A_CYCLE;
  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign pop      = !empty && bus.tx_ready;
  assign push_req = bus.write && (bus.address == A_TX);
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign st_wr    = bus.write && (bus.address == A_STATUS);

`ifdef DMEM_WP_EN
  localparam logic [ADDR_W-1:0] WP_LIM = ADDR_W'(PROTECT_LIMIT);
  assign wp_block = bus.write && is_ram && (bus.address < WP_LIM);
`else
  logic unused_wp_limit;
  assign unused_wp_limit = (PROTECT_LIMIT != 0);
  assign wp_block        = 1'b0;
`endif

  assign ram_we = bus.write && is_ram && !wp_block;

  assign head = empty ? '0 : fifo_mem[rd_ptr];

  always_comb begin
    status       = '0;
    status[7:0]  = 8'(count);
    status[8]    = empty;
    status[9]    = full;
    status[10]   = overflow;
    status[11]   = wp_sticky;
  end

  always_comb begin
    rd_word = '0;
    if (is_ram)                       rd_word = ram[bus.address];
    else if (bus.address == A_CYCLE)  rd_word = cycle;
    else if (bus.address == A_TX)     rd_word = head;
    else if (bus.address == A_STATUS) rd_word = status;
  end

  assign bus.data_in  = bus.read ? rd_word : '0;
  assign bus.tx_valid = !empty;
  assign bus.tx_data  = head;
  assign bus.wp_fault = wp_fault_q;

  always_ff @(posedge clock) begin
    if (ram_we) ram[bus.address] <= bus.data_out;
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= bus.data_out;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      wp_sticky  <= 1'b0;
      wp_fault_q <= 1'b0;
    end else begin
      if (bus.write && (bus.address == A_CYCLE)) cycle <= bus.data_out;
      else                                       cycle <= cycle + 1'b1;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      // Set has priority over a clear in the same cycle.
      if (ovf_set)                        overflow <= 1'b1;
      else if (st_wr && bus.data_out[0])  overflow <= 1'b0;

      if (wp_block)                       wp_sticky <= 1'b1;
      else if (st_wr && bus.data_out[1])  wp_sticky <= 1'b0;

      wp_fault_q <= wp_block;
    end
  end
endmodule

// File: tb/tb_data_memory_unit.sv
// tb/tb_data_memory_unit.sv - scoreboard bench for data_memory_unit.
module tb_data_memory_unit;
  localparam logic [9:0] A_CYC = 10'd1020;
  localparam logic [9:0] A_TX  = 10'd1021;
  localparam logic [9:0] A_ST  = 10'd1022;
  localparam logic [9:0] A_RSV = 10'd1023;

  typedef struct {
    logic [31:0] data;
    bit          chk_wp;
    bit          wp;
    bit          chk_txv;
    bit          txv;
  } rd_exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  rd_exp_t     exp_rd[$];
  string       exp_nm[$];
  logic [31:0] exp_tx[$];

`ifdef DMEM_WP_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  data_memory_unit_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  data_memory_unit #(.ADDR_W(10), .DATA_W(32), .FIFO_DEPTH(8), .PROTECT_LIMIT(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic step(input bit r, input bit w, input logic [9:0] a,
                      input logic [31:0] d, input bit txr);
    @(posedge clock);
    #1;
    bus.read     = r;
    bus.write    = w;
    bus.address  = a;
    bus.data_out = d;
    bus.tx_ready = txr;
  endtask

  task automatic expect_rd(input string nm, input logic [31:0] d, input bit cw,
                           input bit w, input bit ct, input bit t);
    rd_exp_t e;
    e.data = d; e.chk_wp = cw; e.wp = w; e.chk_txv = ct; e.txv = t;
    exp_rd.push_back(e);
    exp_nm.push_back(nm);
  endtask

  always @(negedge clock) begin : monitor
    rd_exp_t     e;
    string       nm;
    logic [31:0] t;
    if (bus.read) begin
      if (exp_rd.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_read addr=%0d data_in=%h required none", bus.address, bus.data_in);
      end else begin
        e  = exp_rd.pop_front();
        nm = exp_nm.pop_front();
        vectors++;
        if (bus.data_in !== e.data) begin
          miscompares++;
          $display("FAIL %s data_in=%h required %h", nm, bus.data_in, e.data);
        end
        if (e.chk_wp) begin
          vectors++;
          if (bus.wp_fault !== e.wp) begin
            miscompares++;
            $display("FAIL %s wp_fault=%b required %b", nm, bus.wp_fault, e.wp);
          end
        end
        if (e.chk_txv) begin
          vectors++;
          if (bus.tx_valid !== e.txv) begin
            miscompares++;
            $display("FAIL %s tx_valid=%b required %b", nm, bus.tx_valid, e.txv);
          end
        end
      end
    end
    if (bus.tx_valid && bus.tx_ready) begin
      vectors++;
      if (exp_tx.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_tx tx_data=%h required none", bus.tx_data);
      end else begin
        t = exp_tx.pop_front();
        if (bus.tx_data !== t) begin
          miscompares++;
          $display("FAIL tx_stream tx_data=%h required %h", bus.tx_data, t);
        end
      end
    end
  end

  initial begin
    bus.read = 1'b0; bus.write = 1'b0; bus.address = '0; bus.data_out = '0; bus.tx_ready = 1'b0;

    // reset state
    step(1, 0, A_ST, 0, 0); expect_rd("reset_status", 32'h100, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0); reset = 1'b0;

    // RAM, read-during-write, reserved
    step(0, 1, 10'd5, 32'hDEADBEEF, 0);
    step(1, 0, 10'd5, 0, 0);            expect_rd("ram_rd", 32'hDEADBEEF, 0, 0, 0, 0);
    step(1, 1, 10'd5, 32'h1, 0);        expect_rd("ram_rw", 32'hDEADBEEF, 0, 0, 0, 0);
    step(1, 0, 10'd5, 0, 0);            expect_rd("ram_after_rw", 32'h1, 0, 0, 0, 0);
    step(1, 1, A_RSV, 32'h1234, 0);     expect_rd("reserved", 32'h0, 0, 0, 0, 0);
    step(1, 0, A_TX, 0, 0);             expect_rd("tx_peek_empty", 32'h0, 0, 0, 1, 0);

    // cycle counter load and wrap
    step(0, 1, A_CYC, 32'hFFFFFFFE, 0);
    step(1, 0, A_CYC, 0, 0);            expect_rd("cycle_load", 32'hFFFFFFFE, 0, 0, 0, 0);
    step(1, 0, A_CYC, 0, 0);            expect_rd("cycle_inc", 32'hFFFFFFFF, 0, 0, 0, 0);
    step(1, 0, A_CYC, 0, 0);            expect_rd("cycle_wrap", 32'h0, 0, 0, 0, 0);

    // overflow: nine pushes into eight entries
    for (int i = 1; i <= 9; i++) begin
      step(0, 1, A_TX, 32'(i), 0);
      if (i <= 8) exp_tx.push_back(32'(i));
    end
    step(1, 0, A_ST, 0, 0);             expect_rd("status_full_ovf", 32'h608, 0, 0, 1, 1);
    step(1, 0, A_TX, 0, 0);             expect_rd("tx_peek_head", 32'h1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);
    step(1, 0, A_ST, 0, 1);             expect_rd("status_drained", 32'h500, 0, 0, 1, 0);
    step(0, 1, A_ST, 32'h1, 0);
    step(1, 0, A_ST, 0, 0);             expect_rd("ovf_clear", 32'h100, 0, 0, 0, 0);

    // push while full with a simultaneous pop
    for (int i = 0; i < 8; i++) begin
      step(0, 1, A_TX, 32'h10 + 32'(i), 0);
      exp_tx.push_back(32'h10 + 32'(i));
    end
    step(0, 1, A_TX, 32'hAA, 1);        exp_tx.push_back(32'hAA);
    step(1, 0, A_ST, 0, 0);             expect_rd("full_push_pop", 32'h208, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);
    step(1, 0, A_ST, 0, 0);             expect_rd("status_empty2", 32'h100, 0, 0, 0, 0);

    // asynchronous reset with words queued
    for (int i = 0; i < 3; i++) step(0, 1, A_TX, 32'h21 + 32'(i), 0);
    step(0, 1, A_CYC, 32'd100, 0);
    step(1, 0, A_CYC, 0, 0);            expect_rd("cycle_100", 32'd100, 0, 0, 0, 0);
    step(1, 0, A_TX, 0, 0);             expect_rd("tx_queued", 32'h21, 0, 0, 1, 1);
    step(1, 0, A_ST, 0, 0); reset = 1'b1;
    expect_rd("rst_status", 32'h100, 0, 0, 1, 0);
    step(1, 0, A_CYC, 0, 0); reset = 1'b0;
    expect_rd("rst_cycle", 32'h0, 0, 0, 1, 0);

    // write protection boundary
    step(0, 1, 10'd3, 32'h55, 0);
    step(1, 0, 10'd3, 0, 0);            expect_rd("wp_ram3", WP ? 32'h0 : 32'h55, 1, WP, 0, 0);
    step(1, 0, A_ST, 0, 0);             expect_rd("wp_status", WP ? 32'h900 : 32'h100, 1, 0, 0, 0);
    step(0, 1, A_ST, 32'h2, 0);
    step(1, 0, A_ST, 0, 0);             expect_rd("wp_clear", 32'h100, 1, 0, 0, 0);
    step(0, 1, 10'd16, 32'h66, 0);
    step(1, 0, 10'd16, 0, 0);           expect_rd("wp_limit16", 32'h66, 1, 0, 0, 0);

    // bounded drain of anything still outstanding
    for (int i = 0; i < 40 && (exp_tx.size() != 0 || exp_rd.size() != 0); i++) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    vectors++;
    if (exp_tx.size() != 0 || exp_rd.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending_tx=%0d pending_rd=%0d required 0", exp_tx.size(), exp_rd.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
